// File: rtl/mem_stage.sv
// MEM stage and MEM/WB register; optional 4-beat 128-bit vector access.
// Define VECTOR_MEM_EN to enable vector beat sequencing.
module mem_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          LANES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_clear,
  input  logic                  wb_stall,
  input  logic [31:0]           mem_instr,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_write,
  input  logic                  mem_mem_read,
  input  logic [1:0]            mem_result_src,
  input  logic                  mem_vector_op,
  input  logic [32*LANES-1:0]   mem_alu_result,
  input  logic [32*LANES-1:0]   mem_write_data,
  input  logic [31:0]           mem_pc_plus_4,
  input  logic [32*LANES-1:0]   mem_imm_ext,
  input  logic [4:0]            mem_rd,
  input  logic [31:0]           mem_read_result,
  output logic [31:0]           wb_instr,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_result_src,
  output logic                  wb_vector_op,
  output logic [32*LANES-1:0]   wb_alu_result,
  output logic [31:0]           wb_pc_plus_4,
  output logic [32*LANES-1:0]   wb_imm_ext,
  output logic [4:0]            wb_rd,
  output logic [32*LANES-1:0]   wb_read_result,
  output logic [31:0]           mem_data_memory_addr,
  output logic [31:0]           mem_data_memory_writedata,
  output logic                  mem_stall_all
);

  localparam int VW = 32 * LANES;

  logic          access;
  logic [1:0]    beat;
  logic          stall_all;
  logic [VW-1:0] load_rr;

  assign access = mem_mem_read | mem_mem_write;

`ifdef VECTOR_MEM_EN
  logic            vaccess;
  logic [2:0][31:0] lane;

  assign vaccess = access & mem_vector_op;

  // beat wraps 3->0 so the next access starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      beat <= 2'd0;
      lane <= '0;
    end else if (vaccess && !wb_stall) begin
      beat <= beat + 2'd1;
      if (beat != 2'd3)
        lane[beat] <= mem_read_result;
    end
  end

  assign stall_all = vaccess & (beat != 2'd3);
  assign mem_data_memory_writedata =
    mem_write_data[{beat, 5'b0} +: 32];
  assign load_rr = vaccess
    ? {mem_read_result, lane[2], lane[1], lane[0]}
    : {{(VW-32){1'b0}}, mem_read_result};
`else
  logic unused_ok;

  assign beat      = 2'd0;
  assign stall_all = 1'b0;
  assign mem_data_memory_writedata = mem_write_data[31:0];
  assign load_rr   = {{(VW-32){1'b0}}, mem_read_result};
  assign unused_ok = ^{access, mem_write_data[VW-1:32]};
`endif

  assign mem_data_memory_addr =
    mem_alu_result[31:0] + {28'd0, beat, 2'b00};
  assign mem_stall_all = stall_all;

  // a vector access holds WB until its last beat lands
  always_ff @(posedge clk) begin
    if (reset || wb_clear) begin
      wb_instr       <= NOP_INSTR;
      wb_reg_write   <= 1'b0;
      wb_result_src  <= 2'b00;
      wb_vector_op   <= 1'b0;
      wb_alu_result  <= '0;
      wb_pc_plus_4   <= 32'd0;
      wb_imm_ext     <= '0;
      wb_rd          <= 5'd0;
      wb_read_result <= '0;
    end else if (!wb_stall && !stall_all) begin
      wb_instr       <= mem_instr;
      wb_reg_write   <= mem_reg_write;
      wb_result_src  <= mem_result_src;
      wb_vector_op   <= mem_vector_op;
      wb_alu_result  <= mem_alu_result;
      wb_pc_plus_4   <= mem_pc_plus_4;
      wb_imm_ext     <= mem_imm_ext;
      wb_rd          <= mem_rd;
      wb_read_result <= load_rr;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps then random traffic
// against a behavioural model of the beat sequence and MEM/WB register.
module tb_mem_stage;

`ifdef VECTOR_MEM_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, wb_clear, wb_stall;
  logic [31:0]  mem_instr;
  logic         mem_reg_write, mem_mem_write, mem_mem_read;
  logic [1:0]   mem_result_src;
  logic         mem_vector_op;
  logic [127:0] mem_alu_result, mem_write_data, mem_imm_ext;
  logic [31:0]  mem_pc_plus_4;
  logic [4:0]   mem_rd;
  logic [31:0]  mem_read_result;
  logic [31:0]  wb_instr;
  logic         wb_reg_write;
  logic [1:0]   wb_result_src;
  logic         wb_vector_op;
  logic [127:0] wb_alu_result, wb_imm_ext, wb_read_result;
  logic [31:0]  wb_pc_plus_4;
  logic [4:0]   wb_rd;
  logic [31:0]  addr, wdata;
  logic         stall_all;

  mem_stage dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear), .wb_stall(wb_stall),
    .mem_instr(mem_instr), .mem_reg_write(mem_reg_write),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_result_src(mem_result_src), .mem_vector_op(mem_vector_op),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext),
    .mem_rd(mem_rd), .mem_read_result(mem_read_result),
    .wb_instr(wb_instr), .wb_reg_write(wb_reg_write),
    .wb_result_src(wb_result_src), .wb_vector_op(wb_vector_op),
    .wb_alu_result(wb_alu_result), .wb_pc_plus_4(wb_pc_plus_4),
    .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd),
    .wb_read_result(wb_read_result),
    .mem_data_memory_addr(addr),
    .mem_data_memory_writedata(wdata),
    .mem_stall_all(stall_all)
  );

  int checks = 0;
  int errors = 0;

  // model: beats already done in the current vector access, words collected
  int           m_done;
  logic [31:0]  m_words [3];
  logic [31:0]  e_instr;
  logic         e_rw, e_vec;
  logic [1:0]   e_rs;
  logic [127:0] e_alu, e_imm, e_rr;
  logic [31:0]  e_pc;
  logic [4:0]   e_rd;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_vec();
    return VEC && (mem_mem_read || mem_mem_write) && mem_vector_op;
  endfunction

  task automatic model_clear();
    e_instr = 32'h0000_0013; e_rw = 0; e_vec = 0; e_rs = 0;
    e_alu = 0; e_imm = 0; e_rr = 0; e_pc = 0; e_rd = 0;
  endtask

  task automatic model_reset();
    m_done = 0;
    foreach (m_words[i]) m_words[i] = 32'd0;
    model_clear();
  endtask

  task automatic cyc();
    bit v, waiting;
    logic [127:0] rr;
    #1;
    v = is_vec();
    waiting = v && (m_done < 3);
    chk("addr", {96'd0, addr},
        {96'd0, mem_alu_result[31:0] + 32'(4 * m_done)});
    chk("wdata", {96'd0, wdata},
        {96'd0, mem_write_data[32*m_done +: 32]});
    chk("stall_all", {127'd0, stall_all}, {127'd0, waiting});
    if (v)
      rr = {mem_read_result, m_words[2], m_words[1], m_words[0]};
    else
      rr = {96'd0, mem_read_result};
    if (reset) begin
      model_reset();
    end else begin
      if (wb_clear) model_clear();
      else if (!wb_stall && !waiting) begin
        e_instr = mem_instr; e_rw = mem_reg_write; e_rs = mem_result_src;
        e_vec = mem_vector_op; e_alu = mem_alu_result;
        e_pc = mem_pc_plus_4; e_imm = mem_imm_ext; e_rd = mem_rd;
        e_rr = rr;
      end
      if (v && !wb_stall) begin
        if (m_done < 3) m_words[m_done] = mem_read_result;
        m_done = (m_done + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_instr", {96'd0, wb_instr}, {96'd0, e_instr});
    chk("wb_reg_write", {127'd0, wb_reg_write}, {127'd0, e_rw});
    chk("wb_result_src", {126'd0, wb_result_src}, {126'd0, e_rs});
    chk("wb_vector_op", {127'd0, wb_vector_op}, {127'd0, e_vec});
    chk("wb_alu_result", wb_alu_result, e_alu);
    chk("wb_pc_plus_4", {96'd0, wb_pc_plus_4}, {96'd0, e_pc});
    chk("wb_imm_ext", wb_imm_ext, e_imm);
    chk("wb_rd", {123'd0, wb_rd}, {123'd0, e_rd});
    chk("wb_read_result", wb_read_result, e_rr);
  endtask

  task automatic idle();
    reset = 0; wb_clear = 0; wb_stall = 0;
    mem_instr = 32'h0000_0033; mem_reg_write = 0; mem_mem_write = 0;
    mem_mem_read = 0; mem_result_src = 0; mem_vector_op = 0;
    mem_alu_result = 0; mem_write_data = 0; mem_imm_ext = 0;
    mem_pc_plus_4 = 0; mem_rd = 0; mem_read_result = 0;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    idle();
    // reset with every input nonzero
    reset = 1; wb_clear = 1; wb_stall = 1;
    mem_instr = 32'hFFFF_FFFF; mem_reg_write = 1; mem_mem_write = 1;
    mem_mem_read = 1; mem_result_src = 2'b11; mem_vector_op = 1;
    mem_alu_result = {4{32'h1234_5678}}; mem_write_data = {4{32'hA5A5_A5A5}};
    mem_imm_ext = {4{32'h0F0F_0F0F}}; mem_pc_plus_4 = 32'h44;
    mem_rd = 5'h1F; mem_read_result = 32'h5555_5555;
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    chk("reset_nop", {96'd0, wb_instr}, {96'd0, 32'h0000_0013});

    // clear holds cleared WB while combinational path follows inputs
    reset = 0; wb_stall = 0; mem_vector_op = 0;
    cyc();
    wb_clear = 0;

    // scalar load
    idle();
    mem_mem_read = 1; mem_reg_write = 1; mem_rd = 5'd1;
    mem_alu_result = 128'h0000_0000_0000_0000_0000_0000_90AB_CDEF;
    mem_pc_plus_4 = 32'h4; mem_read_result = 32'hBAAD_F00D;
    cyc();
    chk("scalar_rr", wb_read_result, 128'h0000_0000_0000_0000_0000_0000_BAAD_F00D);
    chk("scalar_rd", {123'd0, wb_rd}, 128'd1);
    chk("scalar_pc", {96'd0, wb_pc_plus_4}, 128'd4);

    // vector store then vector load
    idle();
    mem_mem_write = 1; mem_vector_op = 1;
    mem_alu_result = {96'd0, 32'h90AB_CDEF};
    mem_write_data = {4{32'hDEAD_BEEF}};
    mem_read_result = 32'hBAAD_F00D;
    repeat (4) cyc();
    mem_mem_write = 0; mem_mem_read = 1; mem_reg_write = 1; mem_rd = 5'd7;
    repeat (4) cyc();

    // wb_stall during beat 1
    mem_read_result = 32'h1111_2222;
    cyc();
    wb_stall = 1;
    repeat (2) cyc();
    wb_stall = 0;
    repeat (3) cyc();

    // reset arriving at beat 2
    repeat (2) cyc();
    reset = 1;
    cyc();
    reset = 0; mem_mem_read = 0;
    cyc();
    mem_mem_read = 1;
    repeat (4) cyc();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      wb_clear = ($urandom_range(0, 19) == 0);
      wb_stall = ($urandom_range(0, 5) == 0);
      mem_instr = $urandom; mem_reg_write = 1'($urandom);
      mem_result_src = 2'($urandom);
      mem_pc_plus_4 = $urandom; mem_rd = 5'($urandom);
      mem_read_result = $urandom; mem_imm_ext = r128();
      // keep the op stable while a vector access is in flight
      if (!(is_vec() && m_done != 0)) begin
        mem_mem_read = 1'($urandom); mem_mem_write = 1'($urandom);
        mem_vector_op = 1'($urandom);
        mem_alu_result = r128(); mem_write_data = r128();
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
